// File: rtl/wrap_event_queue_pkg.sv
// Shared record layout and default widths for the wrap event queue.
// A record is {epoch, count}, with the epoch in the MSBs.
package wrap_event_queue_pkg;

    localparam int DEF_WIDTH       = 3;
    localparam int DEF_EPOCH_WIDTH = 8;
    localparam int DEF_DEPTH       = 4;
    localparam int DEF_DROP_WIDTH  = 8;

    localparam int REC_WIDTH = DEF_EPOCH_WIDTH + DEF_WIDTH;
    localparam int COUNT_LSB = 0;
    localparam int EPOCH_LSB = DEF_WIDTH;

    typedef struct packed {
        logic [DEF_EPOCH_WIDTH-1:0] epoch;
        logic [DEF_WIDTH-1:0]       count;
    } rec_t;

    function automatic rec_t make_rec(input logic [DEF_EPOCH_WIDTH-1:0] epoch,
                                      input logic [DEF_WIDTH-1:0] count);
        rec_t r;
        r.epoch = epoch;
        r.count = count;
        return r;
    endfunction

endpackage

// File: rtl/wrap_event_queue_sync_fifo.sv
// Register-array FIFO with a separate occupancy counter; the head is
// muxed from registered state and forced to zero while empty.
module wrap_event_queue_sync_fifo
    import wrap_event_queue_pkg::*;
#(
    parameter int WIDTH = REC_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW:0]      level_reg;
    logic             pop_eff;
    logic             push_eff;

    assign empty    = (level_reg == '0);
    assign full     = (level_reg == (AW+1)'(DEPTH));
    assign pop_eff  = pop & ~empty;
    // A push into a full FIFO is still taken when the head leaves on the same edge.
    assign push_eff = push & (~full | pop_eff);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_eff) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_eff)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push_eff, pop_eff})
                2'b10:   level_reg <= level_reg + (AW+1)'(1);
                2'b01:   level_reg <= level_reg - (AW+1)'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam logic [AW-1:0] IDX = AW'(gi);
            always_ff @(posedge clk) begin
                if (push_eff && (wr_ptr_reg == IDX)) mem[gi] <= din;
            end
        end
    endgenerate

    assign dout  = empty ? '0 : mem[rd_ptr_reg];
    assign level = level_reg;

endmodule

// File: rtl/wrap_event_queue.sv
// Detects wrap-around of an upstream free-running count, stamps each wrap
// with an epoch number and queues it; lost records are counted.
module wrap_event_queue
    import wrap_event_queue_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int EPOCH_WIDTH = DEF_EPOCH_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int DROP_WIDTH  = DEF_DROP_WIDTH
) (
    input  logic                         CLK,
    input  logic                         ASYNCRESET,
    input  logic [WIDTH-1:0]             I,
    output logic [EPOCH_WIDTH+WIDTH-1:0] O_data,
    output logic                         O_valid,
    input  logic                         O_ready,
    output logic [$clog2(DEPTH):0]       O_level,
    output logic [DROP_WIDTH-1:0]        O_drops
);

    localparam int RW = EPOCH_WIDTH + WIDTH;

    logic [WIDTH-1:0]       prev_reg;
    logic                   prev_valid_reg;
    logic [EPOCH_WIDTH-1:0] epoch_reg;
    logic [DROP_WIDTH-1:0]  drops_reg;

    logic                   wrap;
    logic [EPOCH_WIDTH-1:0] epoch_next;
    logic [RW-1:0]          record;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   drop;

    // prev_valid gates the first sample after reset so no stale compare fires.
    assign wrap       = prev_valid_reg & (I < prev_reg);
    assign epoch_next = epoch_reg + EPOCH_WIDTH'(1);
    assign record     = {epoch_next, I};
    assign drop       = wrap & fifo_full & ~O_ready;

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            prev_reg       <= '0;
            prev_valid_reg <= 1'b0;
            epoch_reg      <= '0;
            drops_reg      <= '0;
        end else begin
            prev_reg       <= I;
            prev_valid_reg <= 1'b1;
            if (wrap) epoch_reg <= epoch_next;
            if (drop && (drops_reg != '1)) drops_reg <= drops_reg + DROP_WIDTH'(1);
        end
    end

    wrap_event_queue_sync_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (ASYNCRESET),
        .push  (wrap),
        .pop   (O_ready),
        .din   (record),
        .dout  (O_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (O_level)
    );

    assign O_valid = ~fifo_empty;
    assign O_drops = drops_reg;

endmodule

// File: tb/tb_wrap_event_queue.sv
// Directed bench for wrap_event_queue: wrap detect, epoch stamping,
// FIFO backpressure, simultaneous push/pop when full and drop saturation.
module tb_wrap_event_queue;
    import wrap_event_queue_pkg::*;

    logic        CLK = 1'b0;
    logic        ASYNCRESET = 1'b1;
    logic [2:0]  I = 3'd0;
    logic [10:0] O_data;
    logic        O_valid;
    logic        O_ready = 1'b0;
    logic [2:0]  O_level;
    logic [7:0]  O_drops;

    int checks = 0;
    int errors = 0;

    wrap_event_queue dut (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .I          (I),
        .O_data     (O_data),
        .O_valid    (O_valid),
        .O_ready    (O_ready),
        .O_level    (O_level),
        .O_drops    (O_drops)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %-16s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        #1 ASYNCRESET = 1'b1;
        #1 ASYNCRESET = 1'b0;
    endtask

    // One wrap: a high sample followed by zero; the wrap fires on the zero.
    task automatic do_wrap();
        I = 3'd7;
        tick();
        I = 3'd0;
        tick();
    endtask

    initial begin
        rec_t exp_rec;
        logic [10:0] exp_q [4];

        // Reset state
        O_ready = 1'b1;
        #12;
        check("rst_valid", 32'(O_valid), 32'd0);
        check("rst_level", 32'(O_level), 32'd0);
        check("rst_data",  32'(O_data),  32'd0);
        check("rst_drops", 32'(O_drops), 32'd0);
        ASYNCRESET = 1'b0;
        tick();

        // Counting 0..7 then 0: single wrap, latency 1, immediate pop
        for (int k = 0; k < 8; k++) begin
            I = 3'(k);
            tick();
            check("count_novalid", 32'(O_valid), 32'd0);
        end
        I = 3'd0;
        #1;
        check("no_bypass", 32'(O_valid), 32'd0);
        tick();
        check("wrap1_valid", 32'(O_valid), 32'd1);
        check("wrap1_data",  32'(O_data),  32'h008);
        check("wrap1_level", 32'(O_level), 32'd1);
        I = 3'd1;
        tick();
        check("pop1_level", 32'(O_level), 32'd0);
        check("pop1_data",  32'(O_data),  32'd0);

        // Equal samples are not a wrap; a non-unit decrease is
        I = 3'd5;
        tick();
        tick();
        check("equal_nowrap", 32'(O_valid), 32'd0);
        I = 3'd2;
        tick();
        exp_rec = make_rec(8'd2, 3'd2);
        check("jump_data", 32'(O_data), 32'(exp_rec));

        // Async reset mid-sequence clears prev_valid and epoch
        I = 3'd6;
        tick();
        O_ready = 1'b0;
        I = 3'd5;
        ASYNCRESET = 1'b1;
        #1;
        check("async_level", 32'(O_level), 32'd0);
        check("async_valid", 32'(O_valid), 32'd0);
        #1 ASYNCRESET = 1'b0;
        I = 3'd3;
        tick();
        check("after_rst_nowrap", 32'(O_valid), 32'd0);
        I = 3'd2;
        tick();
        check("after_rst_data",  32'(O_data),  32'h00A);
        check("after_rst_level", 32'(O_level), 32'd1);
        O_ready = 1'b1;
        tick();
        check("after_rst_pop", 32'(O_level), 32'd0);

        // Backpressure: 6 wraps into a 4-deep FIFO
        O_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 6; k++) do_wrap();
        check("full_level", 32'(O_level), 32'd4);
        check("full_drops", 32'(O_drops), 32'd2);
        check("full_head",  32'(O_data),  32'h008);

        // Head stable for 10 cycles while stalled with no wrap
        for (int k = 0; k < 10; k++) begin
            tick();
            check("stable_data",  32'(O_data),  32'h008);
            check("stable_valid", 32'(O_valid), 32'd1);
        end

        // Full + wrap + pop in the same cycle: epoch register was 6, new record epoch 7
        I = 3'd7;
        tick();
        I = 3'd0;
        O_ready = 1'b1;
        tick();
        check("fpp_level", 32'(O_level), 32'd4);
        check("fpp_drops", 32'(O_drops), 32'd2);
        exp_q[0] = 11'h010;
        exp_q[1] = 11'h018;
        exp_q[2] = 11'h020;
        exp_q[3] = 11'h038;
        for (int k = 0; k < 4; k++) begin
            check("drain_data", 32'(O_data), 32'(exp_q[k]));
            tick();
        end
        check("drain_level", 32'(O_level), 32'd0);
        check("drain_valid", 32'(O_valid), 32'd0);
        check("drain_data0", 32'(O_data),  32'd0);

        // 256 wraps with the consumer ready: epoch rolls over to 0x00
        do_reset();
        for (int n = 1; n <= 256; n++) begin
            do_wrap();
            exp_rec = make_rec(8'(n), 3'd0);
            check("roll_data", 32'(O_data), 32'(exp_rec));
        end
        check("roll_last", 32'(O_data), 32'h000);
        check("roll_valid", 32'(O_valid), 32'd1);
        check("roll_drops", 32'(O_drops), 32'd0);

        // Drop counter saturates at 0xFF
        O_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 4 + 254; k++) do_wrap();
        check("drops_254", 32'(O_drops), 32'hFE);
        for (int k = 0; k < 6; k++) do_wrap();
        check("drops_sat",  32'(O_drops), 32'hFF);
        check("drops_level", 32'(O_level), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wrap_event_queue.md
Name: wrap_event_queue

Overview:
- Downstream consumer of the free-running 3-bit counter stage (Register-based incrementer, O = O + 1 mod 8).
- Watches the sampled count every cycle and detects wrap-around (count decreasing).
- Keeps an epoch counter of wraps and queues one record per wrap into a small FIFO, drained through a valid/ready interface.
- Saturating drop counter records events lost when the FIFO is full.

Parameters:
- WIDTH, 3, width of incoming count value I.
- EPOCH_WIDTH, 8, width of wrap epoch counter (wraps mod 2^EPOCH_WIDTH).
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- DROP_WIDTH, 8, width of saturating drop counter.

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- ASYNCRESET  input  1  reset, asynchronous, active-high.
- I  input  WIDTH  count sample from upstream counter, valid every cycle.
- O_data  output  EPOCH_WIDTH+WIDTH  head record {epoch[EPOCH_WIDTH-1:0], count[WIDTH-1:0]}, epoch in MSBs.
- O_valid  output  1  FIFO non-empty.
- O_ready  input  1  consumer accepts head this cycle.
- O_level  output  clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- O_drops  output  DROP_WIDTH  saturating count of discarded wrap records.

Behaviour:
- Reset (ASYNCRESET=1, takes effect immediately, independent of CLK):
  - prev=0, prev_valid=0, epoch=0.
  - FIFO empty: O_valid=0, O_level=0, O_data=0.
  - O_drops=0.
- Sampling: every cycle prev<=I and prev_valid<=1.
  - First cycle after reset release: no comparison is made, so no wrap can fire.
- Wrap detect (combinational): wrap = prev_valid & (I < prev), unsigned.
  - Equal values are not a wrap.
  - Any decrease counts as a wrap, including a non-unit jump (e.g. 5->2).
- On wrap cycle:
  - epoch <= epoch+1, mod 2^EPOCH_WIDTH; 0xFF -> 0x00 silently.
  - Push record {epoch+1, I}: the record carries the new epoch value.
- Pop: O_valid & O_ready. Head advances on that edge.
- Push accepted iff level<DEPTH, or a pop occurs in the same cycle.
  - Full + push + pop: both happen, level stays DEPTH.
  - Full + push, no pop: record dropped; O_drops+1, saturating at 2^DROP_WIDTH-1; epoch still increments.
- Empty + push: O_valid=1 on the next cycle, so wrap-to-valid latency is 1 cycle. No bypass: O_valid is never asserted in the wrap cycle itself.
- O_data holds the head entry while O_valid=1 and O_ready=0. It must remain stable until popped.
- O_data is 0 whenever the FIFO is empty.
- O_ready while empty: ignored, no state change.
- Pointers: log2(DEPTH)-bit read/write pointers wrap naturally. Occupancy is tracked in a separate counter; full/empty derive from that counter.
- All outputs are registered or derived only from registered state. No combinational path from I or O_ready to any output.

Decomposition:
- Shared package holds:
  - record layout constants: REC_WIDTH = EPOCH_WIDTH+WIDTH, field offsets;
  - default widths;
  - record typedef {epoch, count}.
- One natural sub-module, sync_fifo:
  - parameterised width/depth;
  - push/pop/full/empty/level;
  - async active-high reset.
- Top level keeps wrap detect, epoch counter and drop counter.

Test Plan:
- Drive I=0,1,...,7,0,1 with O_ready=1 -> wrap on the cycle I=0 after 7. O_valid=1 the next cycle with O_data=0x008 (epoch 1, count 0), popped at once. O_level returns to 0.
- Assert reset while I=5 with prev=6 (mid-sequence), release, then drive I=3 -> no record, because prev_valid=0. Next I=2 -> record {1,2}=0x00A.
- O_ready=0, produce 6 wraps -> O_level saturates at 4. Queued records are epochs 1..4. O_drops=2 and the epoch register reads 6. Draining yields 4 records in epoch order.
- FIFO full, O_ready=1 in the same cycle as a wrap -> level stays 4. O_drops unchanged. The new record appears after the 3 older ones.
- 256 wraps with O_ready=1 -> epoch rolls 0xFF->0x00. The 256th record carries epoch 0x00.
- O_ready held 0 on a non-empty FIFO, I steady with no wrap -> O_data and O_valid remain stable for 10 cycles.
- Force >255 drops -> O_drops holds at 0xFF.
